ising_run_ctrl: RTL
===================

Name: ising_run_ctrl

Overview:
Sequencer for one oscillator-array solve in the digital Ising machine.
- Holds a per-spin coupling-weight register file and drives it onto the oscillator array's coupling_weights buses.
- Runs each solve as: hold oscillators in reset, release for a programmed number of cycles, sample relative spin phases, return an N-bit spin vector over a valid/ready handshake.
- Sits between the host configuration logic and the oscillator array.

Parameters:
- N, 8, number of spins/oscillators.
- WW, 3, weight width per coupling.
- CNTW, 16, run-cycle counter width.
- HOLD, 4, cycles osc_rstn is held low before each run (minimum 1).
- SAMPLE_LEN, 15, majority-vote window in cycles (odd, ≤ 2^CNTW-1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_we  in  1  weight-row write strobe.
- cfg_row  in  $clog2(N)  target spin row.
- cfg_data  in  N*WW  row weights; slice j (bits j*WW +: WW) is coupling from spin j.
- start  in  1  begin solve (pulse).
- run_cycles  in  CNTW  free-run duration; latched on accepted start.
- busy  out  1  high in any state other than IDLE.
- osc_rstn  out  1  active-low reset to the oscillator array.
- weights  out  N*N*WW  row i occupies bits i*N*WW +: N*WW.
- osc_out  in  N  asynchronous oscillator outputs.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_spins  out  N  bit i = 1 iff spin i is in phase with spin 0; bit 0 is always 1.

Behaviour:
Reset (rstn low, async):
- State goes to IDLE; weights, all counters, res_spins and res_valid clear to 0.
- osc_rstn = 0, busy = 0.
- Reset mid-solve aborts the solve; no result is produced.

Synchronizer:
- osc_out passes through a 2-flop synchronizer; all logic uses the synchronized value (osc_s).

Configuration writes:
- Accepted only in IDLE. Row cfg_row is written the cycle after cfg_we is high.
- cfg_we in any other state is ignored.
- cfg_row ≥ N is ignored.

FSM states:
- IDLE:
  - osc_rstn = 0.
  - start → HOLD_RST; latch run_cycles into rc.
  - start outside IDLE is ignored.
  - start and cfg_we in the same cycle: the write is applied, and the solve uses the new weights.
- HOLD_RST:
  - osc_rstn = 0 for exactly HOLD cycles, then → RUN.
  - On the RUN entry edge osc_rstn rises.
- RUN:
  - osc_rstn = 1; count rc cycles, then → SAMPLE.
  - rc = 0 skips RUN: HOLD_RST goes straight to SAMPLE, still with osc_rstn = 1.
  - rc = 2^CNTW-1 must be exact; the counter must not wrap.
- SAMPLE:
  - osc_rstn stays 1 for SAMPLE_LEN cycles.
  - Per spin i ≥ 1, agree_i increments each cycle osc_s[i] == osc_s[0].
  - After SAMPLE_LEN cycles: res_spins[i] = (agree_i > SAMPLE_LEN/2); res_spins[0] = 1; res_valid = 1; → DONE.
  - Agree counters are $clog2(SAMPLE_LEN+1) bits wide and clear on SAMPLE entry.
- DONE:
  - osc_rstn = 0 (array parked).
  - res_valid and res_spins stay stable until res_valid && res_ready.
  - On that handshake: res_valid = 0, → IDLE.
  - res_ready while not valid has no effect.

Output timing:
- weights always reflects the register file, including during a solve.
- Latency from start to res_valid, in cycles: 1 + HOLD + rc + SAMPLE_LEN (+1 register stage).

Optional Feature:
Macro MAJORITY_SAMPLE_EN.
- Defined: SAMPLE behaves as described above (majority vote over SAMPLE_LEN cycles).
- Undefined:
  - SAMPLE lasts one cycle; res_spins[i] = (osc_s[i] == osc_s[0]) sampled in that cycle.
  - Agree counters are not built.
  - Latency is 1 + HOLD + rc + 1 (+1).

Decomposition:
- Package ising_ctrl_pkg:
  - state enum (IDLE, HOLD_RST, RUN, SAMPLE, DONE);
  - default values for N, WW, CNTW, HOLD, SAMPLE_LEN;
  - localparam helpers for row/slice widths.
- Sub-module osc_sync: N-bit 2-flop synchronizer with async active-low reset clearing it to 0.
- The weight register file stays inline.

Test Plan:
1. Reset mid-RUN.
   - Stimulus: N=3, write rows, start with run_cycles=100, pull rstn low at cycle 50.
   - Response: weights=0, osc_rstn=0, busy=0, res_valid=0 immediately (asynchronously).
2. Config write and lockout.
   - Stimulus: write row 1 = 9'b100010010, then start; during RUN, write row 1 = 0.
   - Response: weights[17:9] = 9'b100010010 throughout; the busy-time write is ignored.
3. Phase sampling.
   - Stimulus: drive osc_out[0] and osc_out[1] as identical square waves, osc_out[2] inverted; run_cycles=20.
   - Response: res_spins=3'b011, res_valid asserted exactly 1+4+20+15+1 cycles after start.
4. Handshake backpressure.
   - Stimulus: hold res_ready=0 for 10 cycles after res_valid, then pulse it for 1 cycle.
   - Response: res_spins stable throughout; res_valid drops the next cycle; busy=0; a new start is accepted.
5. Zero-length run.
   - Stimulus: start with run_cycles=0.
   - Response: osc_rstn rises after HOLD; SAMPLE follows directly; result after 1+4+0+15+1 cycles.
6. Single-cycle sample (MAJORITY_SAMPLE_EN undefined).
   - Stimulus: osc_out[1] agrees with osc_out[0] only in the sample cycle.
   - Response: res_spins[1]=1; latency 1+4+rc+1+1.

Source files
------------

// File: rtl/ising_ctrl_pkg.sv
// Shared types and default sizing for the Ising machine run controller.
// The optional majority-vote sampler is enabled by defining MAJORITY_SAMPLE_EN.
package ising_ctrl_pkg;

  localparam int N_DEF          = 8;
  localparam int WW_DEF         = 3;
  localparam int CNTW_DEF       = 16;
  localparam int HOLD_DEF       = 4;
  localparam int SAMPLE_LEN_DEF = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD_RST = 3'd1,
    RUN      = 3'd2,
    SAMPLE   = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Width of one weight row (all couplings into a single spin).
  function automatic int row_w(input int n, input int ww);
    return n * ww;
  endfunction

  // Width of a per-spin agreement counter for a vote window of len cycles.
  function automatic int agree_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/ising_run_ctrl_osc_sync.sv
// N-bit two-flop synchronizer bringing the free-running oscillator outputs
// into the clk domain; async active-low reset clears both stages.
module osc_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/ising_run_ctrl.sv
// Solve sequencer for the oscillator array: weight register file, reset/run/sample
// FSM and result handshake. Define MAJORITY_SAMPLE_EN for a SAMPLE_LEN-cycle vote.
module ising_run_ctrl
  import ising_ctrl_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int WW         = WW_DEF,
  parameter int CNTW       = CNTW_DEF,
  parameter int HOLD       = HOLD_DEF,
  parameter int SAMPLE_LEN = SAMPLE_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_we,
  input  logic [$clog2(N)-1:0]  cfg_row,
  input  logic [N*WW-1:0]       cfg_data,
  input  logic                  start,
  input  logic [CNTW-1:0]       run_cycles,
  output logic                  busy,
  output logic                  osc_rstn,
  output logic [N*N*WW-1:0]     weights,
  input  logic [N-1:0]          osc_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [N-1:0]          res_spins
);

  localparam int RW  = row_w(N, WW);
  localparam int RIW = $clog2(N);
`ifdef MAJORITY_SAMPLE_EN
  localparam int SAMPLE_CYC = SAMPLE_LEN;
  localparam int AW         = agree_w(SAMPLE_LEN);
`else
  localparam int SAMPLE_CYC = 1;
`endif
  localparam logic [CNTW-1:0] HOLD_LAST   = CNTW'(HOLD - 1);
  localparam logic [CNTW-1:0] SAMPLE_LAST = CNTW'(SAMPLE_CYC - 1);

  state_t          state_reg, state_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic [CNTW-1:0] rc_reg, rc_next;
  logic            pend_reg;
  logic            res_valid_reg;
  logic [N-1:0]    res_spins_reg;
  logic [N-1:0]    osc_s;
  logic [N-1:0]    vote;
  logic            sample_entry;

  osc_sync #(.W(N)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (osc_out),
    .q    (osc_s)
  );

  // Weight rows only accept writes while idle; out-of-range rows match nothing.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_row
      logic [RW-1:0] row_reg;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          row_reg <= '0;
        else if (cfg_we && (state_reg == IDLE) && (cfg_row == RIW'(gi)))
          row_reg <= cfg_data;
      end
      assign weights[gi*RW +: RW] = row_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rc_next    = rc_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = HOLD_RST;
          rc_next    = run_cycles;
          cnt_next   = '0;
        end
      end
      HOLD_RST: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = (rc_reg == '0) ? SAMPLE : RUN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        // Compare against rc-1 so a full-scale rc never needs the counter to wrap.
        if (cnt_reg == (rc_reg - 1'b1)) begin
          cnt_next   = '0;
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SAMPLE: begin
        if (cnt_reg == SAMPLE_LAST) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (res_valid_reg && res_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sample_entry = (state_next == SAMPLE) && (state_reg != SAMPLE);

  assign vote[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_vote
`ifdef MAJORITY_SAMPLE_EN
      logic [AW-1:0] agree_reg;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          agree_reg <= '0;
        else if (sample_entry)
          agree_reg <= '0;
        else if ((state_reg == SAMPLE) && (osc_s[gi] == osc_s[0]))
          agree_reg <= agree_reg + 1'b1;
      end
      assign vote[gi] = (agree_reg > AW'(SAMPLE_LEN / 2));
`else
      logic match_reg;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          match_reg <= 1'b0;
        else if (state_reg == SAMPLE)
          match_reg <= (osc_s[gi] == osc_s[0]);
      end
      assign vote[gi] = match_reg;
`endif
    end
  endgenerate

  // The decision is registered one cycle after SAMPLE ends so it sees the final sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rc_reg        <= '0;
      pend_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      res_spins_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rc_reg    <= rc_next;
      if ((state_reg == SAMPLE) && (state_next == DONE)) begin
        pend_reg <= 1'b1;
      end else if (pend_reg) begin
        pend_reg      <= 1'b0;
        res_valid_reg <= 1'b1;
        res_spins_reg <= vote;
      end else if (res_valid_reg && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign osc_rstn  = (state_reg == RUN) || (state_reg == SAMPLE);
  assign res_valid = res_valid_reg;
  assign res_spins = res_spins_reg;

endmodule
